// File: rtl/vip_uart_transmitter_fifo_if.sv
// vip_uart_transmitter_fifo_if: byte-write side and serial line of the queued UART transmitter
interface vip_uart_transmitter_fifo_if;
  logic       i_we;
  logic [7:0] i_wdata;
  logic       o_full;
  logic       o_empty;
  logic       o_busy;
  logic       o_overflow;
  logic       o_tx;
  modport master (output i_we, i_wdata, input o_full, o_empty, o_busy, o_overflow, o_tx);
  modport slave (input i_we, i_wdata, output o_full, o_empty, o_busy, o_overflow, o_tx);
endinterface

// File: rtl/vip_uart_transmitter_fifo.sv
// vip_uart_transmitter_fifo: FIFO-queued UART frame generator driving a serial RX pin
module vip_uart_transmitter_fifo #(
  parameter int scaler     = 8,
  parameter int data_bits  = 8,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0,
  parameter int stop_bits  = 1,
  parameter int fifo_log2  = 2
) (
  input logic i_clk,
  input logic i_nrst,
  vip_uart_transmitter_fifo_if.slave bus
);
  localparam int depth = 2 ** fifo_log2;
  localparam int cw = $clog2(2 * scaler);
  localparam logic [7:0] mask = 8'((1 << data_bits) - 1);
  localparam logic [2:0] last_bit = 3'(data_bits - 1);
  localparam logic two_stop = stop_bits == 2;
  typedef enum logic [2:0] {idle, startbit, data, parity, stopbit} state_t;
  typedef logic [fifo_log2:0] cnt_t;
  typedef logic [fifo_log2-1:0] ptr_t;
  state_t r_state, w_state;
  logic [7:0] r_mem [depth];
  ptr_t r_wptr, r_rptr;
  cnt_t r_count, w_count;
  logic [cw-1:0] r_sample;
  logic [7:0] r_shift, w_shift, w_head;
  logic [2:0] r_bitpos, w_bitpos;
  logic r_stopcnt, w_stopcnt, r_par, w_par, r_tx, w_tx;
  logic r_full, r_empty, r_overflow, r_busy, w_tick, w_push, w_pop;

  assign w_tick = r_sample == cw'(2 * scaler - 1);
  assign w_push = bus.i_we & ~r_full;
  assign w_head = r_mem[r_rptr];
  assign w_count = r_count + cnt_t'(w_push) - cnt_t'(w_pop);

  // Parity is latched at pop time because the shift register consumes the data.
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_par = r_par;
    w_bitpos = r_bitpos;
    w_stopcnt = r_stopcnt;
    w_tx = r_tx;
    w_pop = 1'b0;
    if (w_tick)
      case (r_state)
        idle, stopbit:
          if (r_state == stopbit && two_stop && !r_stopcnt) w_stopcnt = 1'b1;
          else if (!r_empty) begin
            w_pop = 1'b1;
            w_shift = w_head;
            w_par = ^(w_head & mask) ^ (parity_odd != 0);
            w_tx = 1'b0;
            w_state = startbit;
          end else begin
            w_tx = 1'b1;
            w_state = idle;
          end
        startbit: begin
          w_tx = r_shift[0];
          w_bitpos = '0;
          w_state = data;
        end
        data:
          if (r_bitpos != last_bit) begin
            w_shift = {1'b1, r_shift[7:1]};
            w_tx = r_shift[1];
            w_bitpos = r_bitpos + 3'd1;
          end else if (parity_en != 0) begin
            w_tx = r_par;
            w_state = parity;
          end else begin
            w_tx = 1'b1;
            w_stopcnt = 1'b0;
            w_state = stopbit;
          end
        parity: begin
          w_tx = 1'b1;
          w_stopcnt = 1'b0;
          w_state = stopbit;
        end
        default: w_state = idle;
      endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      r_state <= idle;
      r_sample <= '0;
      r_shift <= '1;
      r_par <= 1'b0;
      r_bitpos <= '0;
      r_stopcnt <= 1'b0;
      r_tx <= 1'b1;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
      r_overflow <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sample <= w_tick ? '0 : r_sample + cw'(1);
      r_shift <= w_shift;
      r_par <= w_par;
      r_bitpos <= w_bitpos;
      r_stopcnt <= w_stopcnt;
      r_tx <= w_tx;
      if (w_push) r_wptr <= r_wptr + ptr_t'(1);
      if (w_pop) r_rptr <= r_rptr + ptr_t'(1);
      r_count <= w_count;
      r_full <= w_count == cnt_t'(depth);
      r_empty <= w_count == '0;
      r_overflow <= bus.i_we & r_full;
      r_busy <= w_state != idle;
    end

  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= bus.i_wdata;

  assign bus.o_tx = r_tx;
  assign bus.o_full = r_full;
  assign bus.o_empty = r_empty;
  assign bus.o_busy = r_busy;
  assign bus.o_overflow = r_overflow;
endmodule
